// File: rtl/smith_waterman.sv
// rtl/smith_waterman.sv - batch Smith-Waterman (Gotoh affine gap) scoring engine
module smith_waterman #(
    parameter int SRAM_WORD_WIDTH = 8,
    parameter int SRAM_ADDR_BIT   = 16,
    parameter int CALC_BIT        = 16,
    parameter int MAX_T_NUM_BIT   = 8,
    parameter int MATCH_BIT       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       select_T_o,
    output logic [SRAM_ADDR_BIT-1:0]   addr_o,
    input  logic [SRAM_WORD_WIDTH-1:0] data_i,
    output logic [CALC_BIT-1:0]        result_o,
    output logic                       valid_o,
    output logic                       change_q_o,
    output logic [MAX_T_NUM_BIT-1:0]   match_idx_o,
    output logic [CALC_BIT-1:0]        max_result_o,
    input  logic [MATCH_BIT-1:0]       match_i,
    input  logic [MATCH_BIT-1:0]       mismatch_i,
    input  logic [MATCH_BIT-1:0]       alpha_i,
    input  logic [MATCH_BIT-1:0]       beta_i
);
    localparam int LEN_BIT = 8;
    // Two guard bits keep H+s and -inf-beta from wrapping before saturation.
    localparam int W = CALC_BIT + 2;
    // Real E/F values never drop below -2*2^MATCH_BIT, so this stands in for -inf.
    localparam logic signed [W-1:0] NEG_INF = {2'b11, {CALC_BIT{1'b0}}};
    localparam logic signed [W-1:0] H_MAX   = {2'b00, {CALC_BIT{1'b1}}};

    typedef enum logic [3:0] {
        S_IDLE, S_RD_NQ, S_RD_NT, S_Q_LEN, S_T_LEN, S_ROW, S_CELL, S_EMIT, S_DONE
    } state_t;

    state_t state, state_next;

    logic [LEN_BIT-1:0]       nq, nt, q_idx, t_idx, lq, lt, i, j;
    logic [SRAM_ADDR_BIT-1:0] q_addr, t_addr;
    logic [1:0]               qb;
    logic signed [W-1:0]      h_left, e_left, h_diag;
    logic [CALC_BIT-1:0]      pair_best, q_best;
    logic [MAX_T_NUM_BIT-1:0] q_best_idx;
    logic [CALC_BIT-1:0]      hbuf [0:255];
    logic signed [W-1:0]      fbuf [0:255];

    logic [LEN_BIT-1:0]  data_len;
    logic signed [W-1:0] match_s, mismatch_s, alpha_s, beta_s;
    logic signed [W-1:0] h_up, f_up, s_val, e_a, e_b, e_new, f_a, f_b, f_new, d_val, h_raw, h_cell;
    logic [CALC_BIT-1:0] h_cell_u;

    assign data_len   = data_i[LEN_BIT-1:0];
    assign busy_o     = (state != S_IDLE);
    assign match_s    = {{(W-MATCH_BIT){1'b0}}, match_i};
    assign mismatch_s = {{(W-MATCH_BIT){1'b0}}, mismatch_i};
    assign alpha_s    = {{(W-MATCH_BIT){1'b0}}, alpha_i};
    assign beta_s     = {{(W-MATCH_BIT){1'b0}}, beta_i};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic and memory address generation
    always_comb begin
        state_next = state;
        select_T_o = 1'b0;
        addr_o     = '0;
        case (state)
            S_IDLE:  if (start_i) state_next = S_RD_NQ;
            S_RD_NQ: state_next = S_RD_NT;
            S_RD_NT: begin
                select_T_o = 1'b1;
                state_next = (nq == '0 || data_len == '0) ? S_IDLE : S_Q_LEN;
            end
            S_Q_LEN: begin
                addr_o     = q_addr;
                state_next = S_T_LEN;
            end
            S_T_LEN: begin
                select_T_o = 1'b1;
                addr_o     = t_addr;
                state_next = (lq == '0 || data_len == '0) ? S_EMIT : S_ROW;
            end
            S_ROW: begin
                addr_o     = q_addr + SRAM_ADDR_BIT'(i);
                state_next = S_CELL;
            end
            S_CELL: begin
                select_T_o = 1'b1;
                addr_o     = t_addr + SRAM_ADDR_BIT'(j);
                if (j == lt) state_next = (i == lq) ? S_EMIT : S_ROW;
            end
            S_EMIT: begin
                if (t_idx != nt - LEN_BIT'(1))      state_next = S_T_LEN;
                else if (q_idx != nq - LEN_BIT'(1)) state_next = S_Q_LEN;
                else                                state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // One DP cell: row 1 sees the H=0 / F=-inf boundary instead of the row buffers
    always_comb begin
        h_up   = (i == LEN_BIT'(1)) ? '0 : {2'b00, hbuf[j]};
        f_up   = (i == LEN_BIT'(1)) ? NEG_INF : fbuf[j];
        s_val  = (qb == data_i[1:0]) ? match_s : -mismatch_s;
        e_a    = h_left - alpha_s;
        e_b    = e_left - beta_s;
        e_new  = (e_a > e_b) ? e_a : e_b;
        f_a    = h_up - alpha_s;
        f_b    = f_up - beta_s;
        f_new  = (f_a > f_b) ? f_a : f_b;
        d_val  = h_diag + s_val;
        h_raw  = '0;
        if (d_val > h_raw) h_raw = d_val;
        if (e_new > h_raw) h_raw = e_new;
        if (f_new > h_raw) h_raw = f_new;
        h_cell   = (h_raw > H_MAX) ? H_MAX : h_raw;
        h_cell_u = h_cell[CALC_BIT-1:0];
    end

    // Row buffers: H and F of the previous query row, indexed by target position
    always_ff @(posedge clk) begin
        if (state == S_CELL) begin
            hbuf[j] <= h_cell_u;
            fbuf[j] <= f_new;
        end
    end

    // Sequence walking, per-row scan state, and result/best-target reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            nq <= '0; nt <= '0; q_idx <= '0; t_idx <= '0;
            lq <= '0; lt <= '0; i <= '0; j <= '0;
            q_addr <= '0; t_addr <= '0; qb <= '0;
            h_left <= '0; e_left <= '0; h_diag <= '0;
            pair_best <= '0; q_best <= '0; q_best_idx <= '0;
            valid_o <= 1'b0; change_q_o <= 1'b0; result_o <= '0;
            match_idx_o <= '0; max_result_o <= '0;
        end else begin
            valid_o    <= 1'b0;
            change_q_o <= 1'b0;
            case (state)
                S_RD_NQ: nq <= data_len;
                S_RD_NT: begin
                    nt     <= data_len;
                    q_addr <= SRAM_ADDR_BIT'(1);
                    q_idx  <= '0;
                end
                S_Q_LEN: begin
                    lq         <= data_len;
                    t_addr     <= SRAM_ADDR_BIT'(1);
                    t_idx      <= '0;
                    q_best     <= '0;
                    q_best_idx <= '0;
                end
                S_T_LEN: begin
                    lt        <= data_len;
                    pair_best <= '0;
                    i         <= LEN_BIT'(1);
                end
                S_ROW: begin
                    qb     <= data_i[1:0];
                    j      <= LEN_BIT'(1);
                    h_left <= '0;
                    e_left <= NEG_INF;
                    h_diag <= '0;
                end
                S_CELL: begin
                    h_diag <= h_up;
                    h_left <= h_cell;
                    e_left <= e_new;
                    if (h_cell_u > pair_best) pair_best <= h_cell_u;
                    j <= j + LEN_BIT'(1);
                    if (j == lt) i <= i + LEN_BIT'(1);
                end
                S_EMIT: begin
                    valid_o    <= 1'b1;
                    result_o   <= pair_best;
                    change_q_o <= (t_idx == nt - LEN_BIT'(1));
                    // Strictly greater keeps the lowest index on ties.
                    if (pair_best > q_best) begin
                        q_best       <= pair_best;
                        q_best_idx   <= MAX_T_NUM_BIT'(t_idx);
                        max_result_o <= pair_best;
                        match_idx_o  <= MAX_T_NUM_BIT'(t_idx);
                    end else begin
                        max_result_o <= q_best;
                        match_idx_o  <= q_best_idx;
                    end
                    t_idx  <= t_idx + LEN_BIT'(1);
                    t_addr <= t_addr + SRAM_ADDR_BIT'(lt) + SRAM_ADDR_BIT'(1);
                    if (t_idx == nt - LEN_BIT'(1)) begin
                        q_idx  <= q_idx + LEN_BIT'(1);
                        q_addr <= q_addr + SRAM_ADDR_BIT'(lq) + SRAM_ADDR_BIT'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_smith_waterman.sv
// tb/tb_smith_waterman.sv - self-checking bench for smith_waterman
module tb_smith_waterman;
    localparam int NEG = -1000000;

    logic        clk = 1'b0;
    logic        rst, start_i, busy_o, select_T_o, valid_o, change_q_o;
    logic [15:0] addr_o, result_o, max_result_o;
    logic [7:0]  data_i, match_idx_o;
    logic [3:0]  match_i, mismatch_i, alpha_i, beta_i;

    logic [7:0] qmem [0:1023];
    logic [7:0] tmem [0:1023];
    int qptr, tptr;
    int checks = 0, failures = 0;
    int got_res[$], got_chg[$], got_idx[$], got_max[$];
    int exp_res[$], exp_chg[$], exp_idx[$], exp_max[$];
    int last_cyc, last_valid;

    always #5 clk = ~clk;

    assign data_i = select_T_o ? tmem[addr_o[9:0]] : qmem[addr_o[9:0]];

    smith_waterman dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o),
        .select_T_o(select_T_o), .addr_o(addr_o), .data_i(data_i),
        .result_o(result_o), .valid_o(valid_o), .change_q_o(change_q_o),
        .match_idx_o(match_idx_o), .max_result_o(max_result_o),
        .match_i(match_i), .mismatch_i(mismatch_i), .alpha_i(alpha_i), .beta_i(beta_i)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 1024; k++) begin
            qmem[k] = 8'd0;
            tmem[k] = 8'd0;
        end
        qptr = 1;
        tptr = 1;
    endtask

    // Base words carry random upper bits; only bits [1:0] encode the base.
    task automatic put_base(input bit is_t, input int addr, input logic [1:0] b);
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        w[1:0] = b;
        if (is_t) tmem[addr] = w;
        else      qmem[addr] = w;
    endtask

    task automatic add_seq(input bit is_t, input string s);
        int p;
        logic [1:0] b;
        p = is_t ? tptr : qptr;
        if (is_t) begin tmem[p] = 8'(s.len()); tmem[0] = tmem[0] + 8'd1; end
        else      begin qmem[p] = 8'(s.len()); qmem[0] = qmem[0] + 8'd1; end
        for (int k = 0; k < s.len(); k++) begin
            case (s[k])
                8'h41:   b = 2'd0;
                8'h43:   b = 2'd1;
                8'h47:   b = 2'd2;
                default: b = 2'd3;
            endcase
            put_base(is_t, p + 1 + k, b);
        end
        if (is_t) tptr = p + s.len() + 1;
        else      qptr = p + s.len() + 1;
    endtask

    task automatic add_rand(input bit is_t, input int len);
        int p;
        p = is_t ? tptr : qptr;
        if (is_t) begin tmem[p] = 8'(len); tmem[0] = tmem[0] + 8'd1; end
        else      begin qmem[p] = 8'(len); qmem[0] = qmem[0] + 8'd1; end
        for (int k = 0; k < len; k++) put_base(is_t, p + 1 + k, 2'($urandom_range(0, 3)));
        if (is_t) tptr = p + len + 1;
        else      qptr = p + len + 1;
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Full-matrix Gotoh recurrence straight from the scoring rules.
    function automatic int model_score(input int qa, input int ta);
        int lq, lt, s, h, best;
        int hm [0:32][0:32];
        int em [0:32][0:32];
        int fm [0:32][0:32];
        lq = int'(qmem[qa]);
        lt = int'(tmem[ta]);
        best = 0;
        for (int i = 0; i <= lq; i++)
            for (int j = 0; j <= lt; j++) begin
                hm[i][j] = 0; em[i][j] = NEG; fm[i][j] = NEG;
            end
        for (int i = 1; i <= lq; i++)
            for (int j = 1; j <= lt; j++) begin
                s = (qmem[qa+i][1:0] == tmem[ta+j][1:0]) ? int'(match_i) : -int'(mismatch_i);
                em[i][j] = max2(hm[i][j-1] - int'(alpha_i), em[i][j-1] - int'(beta_i));
                fm[i][j] = max2(hm[i-1][j] - int'(alpha_i), fm[i-1][j] - int'(beta_i));
                h = max2(max2(0, hm[i-1][j-1] + s), max2(em[i][j], fm[i][j]));
                if (h > 65535) h = 65535;
                hm[i][j] = h;
                best = max2(best, h);
            end
        return best;
    endfunction

    task automatic build_expected();
        int qa, ta, sc, best, bi;
        exp_res.delete(); exp_chg.delete(); exp_idx.delete(); exp_max.delete();
        if (qmem[0] == 0 || tmem[0] == 0) return;
        qa = 1;
        for (int q = 0; q < int'(qmem[0]); q++) begin
            best = 0; bi = 0; ta = 1;
            for (int t = 0; t < int'(tmem[0]); t++) begin
                sc = model_score(qa, ta);
                if (sc > best) begin best = sc; bi = t; end
                exp_res.push_back(sc);
                exp_chg.push_back((t == int'(tmem[0]) - 1) ? 1 : 0);
                exp_idx.push_back(bi);
                exp_max.push_back(best);
                ta = ta + int'(tmem[ta]) + 1;
            end
            qa = qa + int'(qmem[qa]) + 1;
        end
    endtask

    // Starts a batch and collects pulses until busy drops; restart_at pulses start_i while busy.
    task automatic run_batch(input int restart_at);
        int cyc;
        bit done;
        got_res.delete(); got_chg.delete(); got_idx.delete(); got_max.delete();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        check("busy_rise", int'(busy_o), 1);
        cyc = 0; done = 1'b0; last_valid = -10;
        while (cyc < 20000) begin
            if (valid_o) begin
                got_res.push_back(int'(result_o));
                got_chg.push_back(int'(change_q_o));
                got_idx.push_back(int'(match_idx_o));
                got_max.push_back(int'(max_result_o));
                last_valid = cyc;
            end
            if (!busy_o) begin done = 1'b1; break; end
            start_i = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        last_cyc = cyc;
        check("batch_terminates", int'(done), 1);
        if (got_res.size() > 0) check("busy_fall_gap", last_cyc - last_valid, 1);
    endtask

    task automatic compare_model(input string tag);
        int n;
        build_expected();
        check({tag, "_pulse_count"}, got_res.size(), exp_res.size());
        n = (got_res.size() < exp_res.size()) ? got_res.size() : exp_res.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_result[%0d]", tag, k), got_res[k], exp_res[k]);
            check($sformatf("%s_change_q[%0d]", tag, k), got_chg[k], exp_chg[k]);
            if (exp_chg[k] == 1) begin
                check($sformatf("%s_match_idx[%0d]", tag, k), got_idx[k], exp_idx[k]);
                check($sformatf("%s_max_result[%0d]", tag, k), got_max[k], exp_max[k]);
            end
        end
    endtask

    task automatic set_params(input int m, input int mm, input int a, input int b);
        match_i = 4'(m); mismatch_i = 4'(mm); alpha_i = 4'(a); beta_i = 4'(b);
    endtask

    task automatic setup_case1();
        set_params(6, 1, 2, 1);
        clear_mem();
        add_seq(1'b0, "ACGT");
        add_seq(1'b1, "ACGT");
        add_seq(1'b1, "TTTT");
    endtask

    task automatic check_case1(input string tag);
        compare_model(tag);
        check({tag, "_res0"}, got_res[0], 24);
        check({tag, "_chg0"}, got_chg[0], 0);
        check({tag, "_res1"}, got_res[1], 6);
        check({tag, "_chg1"}, got_chg[1], 1);
        check({tag, "_idx1"}, got_idx[1], 0);
        check({tag, "_max1"}, got_max[1], 24);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0;
        set_params(6, 1, 2, 1);
        clear_mem();
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy_o), 0);
        check("reset_valid", int'(valid_o), 0);
        check("reset_result", int'(result_o), 0);
        check("reset_change_q", int'(change_q_o), 0);
        check("reset_match_idx", int'(match_idx_o), 0);
        check("reset_max_result", int'(max_result_o), 0);
        check("reset_addr", int'(addr_o), 0);
        check("reset_select", int'(select_T_o), 0);
        rst = 1'b0;

        // Basic pair scoring and best-target reporting.
        setup_case1();
        run_batch(-1);
        check_case1("case1");
        @(negedge clk);
        check("case1_busy_idle", int'(busy_o), 0);

        // Mismatch and single-gap alignments.
        clear_mem();
        add_seq(1'b0, "ACGT"); add_seq(1'b0, "AACC");
        add_seq(1'b1, "AGGT"); add_seq(1'b1, "AAGCC");
        run_batch(-1);
        compare_model("case2");
        check("case2_mismatch", got_res[0], 17);
        check("case2_gap", got_res[3], 22);

        // Tie on equal targets, zero-length target, two queries.
        clear_mem();
        add_seq(1'b0, "ACG"); add_seq(1'b0, "GTTA");
        add_seq(1'b1, "ACG"); add_seq(1'b1, "ACG"); add_seq(1'b1, "");
        run_batch(-1);
        compare_model("case3");
        check("case3_tie_a", got_res[0], 18);
        check("case3_tie_b", got_res[1], 18);
        check("case3_len0", got_res[2], 0);
        check("case3_tie_idx", got_idx[2], 0);
        check("case3_q0_last", got_chg[2], 1);
        check("case3_q1_last", got_chg[5], 1);

        // Empty target set: no pulses, busy drops quickly.
        clear_mem();
        add_seq(1'b0, "ACGT");
        run_batch(-1);
        check("case4_no_pulses", got_res.size(), 0);
        check("case4_quick_idle", int'(last_cyc <= 4), 1);

        // start_i while busy is ignored.
        clear_mem();
        add_seq(1'b0, "ACGTAC"); add_seq(1'b0, "GG");
        add_seq(1'b1, "CGTA"); add_seq(1'b1, "TTAC"); add_seq(1'b1, "G");
        run_batch(3);
        compare_model("case5");
        check("case5_count", got_res.size(), 6);
        @(negedge clk);
        check("case5_stays_idle", int'(busy_o), 0);

        // Reset mid-batch aborts, then a clean rerun.
        setup_case1();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("case6_abort_busy", int'(busy_o), 0);
        check("case6_abort_valid", int'(valid_o), 0);
        rst = 1'b0;
        run_batch(-1);
        check_case1("case6_rerun");

        // Randomized batches against the model.
        for (int r = 0; r < 8; r++) begin
            set_params($urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 15));
            clear_mem();
            for (int q = 0; q < int'($urandom_range(1, 3)); q++) add_rand(1'b0, $urandom_range(0, 10));
            for (int t = 0; t < int'($urandom_range(1, 4)); t++) add_rand(1'b1, $urandom_range(0, 10));
            run_batch(-1);
            compare_model($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
